// File: rtl/instr_fetch_buffer.sv
// Fetch stage: issues the PC to a 1-cycle synchronous instruction memory and queues
// the returned {instr, pc} pairs in a small FIFO toward decode, with redirect flush.
module instr_fetch_buffer #(
  parameter int          DEPTH    = 2,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [31:0]              pc_in,
  output logic                     pc_hold,
  output logic [31:0]              imem_addr,
  output logic                     imem_req,
  input  logic [31:0]              imem_rdata,
  input  logic                     redirect,
  output logic                     id_valid,
  input  logic                     id_ready,
  output logic [31:0]              id_instr,
  output logic [31:0]              id_pc,
  output logic [25:0]              id_jump_target,
  output logic [31:0]              id_branch_off,
  output logic [$clog2(DEPTH):0]   occupancy
);

  localparam int PW = $clog2(DEPTH);

  logic [31:0]   instr_mem [DEPTH];
  logic [31:0]   pc_mem    [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [PW:0]   count;
  logic          inflight;
  logic [31:0]   req_pc;

  logic          pop;
  logic          push;
  logic [PW+1:0] credit_use;

  assign pop  = id_valid && id_ready;
  assign push = inflight && !redirect;

  // A read is only issued when its word is guaranteed a slot on arrival,
  // so the FIFO can never overflow even with decode stalled.
  assign credit_use = {1'b0, count} + {{(PW + 1){1'b0}}, inflight}
                    - {{(PW + 1){1'b0}}, pop};
  assign imem_req   = !rst && !redirect && (credit_use < (PW + 2)'(DEPTH));
  assign pc_hold    = !imem_req;
  assign imem_addr  = pc_in;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      inflight <= 1'b0;
      req_pc   <= '0;
    end else begin
      inflight <= imem_req;
      req_pc   <= pc_in;
      if (redirect) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        if (push && !pop)
          count <= count + 1'b1;
        else if (!push && pop)
          count <= count - 1'b1;
      end
    end
  end

  // Storage needs no reset: entries are only observed while count says they are live.
  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem[wr_ptr] <= imem_rdata;
      pc_mem[wr_ptr]    <= req_pc;
    end
  end

  assign id_valid = (count != '0);

  always_comb begin
    id_instr = NOP_WORD;
    id_pc    = '0;
    if (id_valid) begin
      id_instr = instr_mem[rd_ptr];
      id_pc    = pc_mem[rd_ptr];
    end
  end

  assign id_jump_target = id_instr[25:0];
  assign id_branch_off  = {{16{id_instr[15]}}, id_instr[15:0]};
  assign occupancy      = count;

endmodule

// File: tb/tb_instr_fetch_buffer.sv
// Bench for instr_fetch_buffer: queue-based fetch model checked every cycle, plus
// directed literal checks for reset, backpressure, redirect, fields and async reset.
module tb_instr_fetch_buffer;

  localparam int          DEPTH    = 2;
  localparam logic [31:0] NOP_WORD = 32'h0000_0000;
  localparam logic [31:0] GARBAGE  = 32'hDEAD_BEEF;

  logic                   clk = 1'b0;
  logic                   rst = 1'b0;
  logic [31:0]            pc_in = '0;
  logic                   pc_hold;
  logic [31:0]            imem_addr;
  logic                   imem_req;
  logic [31:0]            imem_rdata = GARBAGE;
  logic                   redirect;
  logic                   id_valid;
  logic                   id_ready;
  logic [31:0]            id_instr;
  logic [31:0]            id_pc;
  logic [25:0]            id_jump_target;
  logic [31:0]            id_branch_off;
  logic [$clog2(DEPTH):0] occupancy;

  logic [31:0] redirect_target;
  logic        check_en = 1'b0;
  int          total_checks = 0;
  int          passed_checks = 0;

  // Model: FIFO contents as {instr, pc} pairs plus one outstanding read.
  logic [63:0] mq[$];
  logic        pend_valid = 1'b0;
  logic [31:0] pend_pc = '0;
  logic        m_req;
  logic        m_pop;
  logic [31:0] exp_instr;
  logic [31:0] exp_pc;
  logic        exp_req;

  instr_fetch_buffer #(.DEPTH(DEPTH), .NOP_WORD(NOP_WORD)) dut (
    .clk            (clk),
    .rst            (rst),
    .pc_in          (pc_in),
    .pc_hold        (pc_hold),
    .imem_addr      (imem_addr),
    .imem_req       (imem_req),
    .imem_rdata     (imem_rdata),
    .redirect       (redirect),
    .id_valid       (id_valid),
    .id_ready       (id_ready),
    .id_instr       (id_instr),
    .id_pc          (id_pc),
    .id_jump_target (id_jump_target),
    .id_branch_off  (id_branch_off),
    .occupancy      (occupancy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0080: return 32'h1000_FFFC;
      32'h0000_0081: return 32'h0800_0010;
      default:       return 32'hA000_0000 + a;
    endcase
  endfunction

  function automatic logic model_req();
    int used;
    used = mq.size() + (pend_valid ? 1 : 0) - ((mq.size() != 0 && id_ready) ? 1 : 0);
    return !rst && !redirect && (used < DEPTH);
  endfunction

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    total_checks++;
    if (actual !== expected)
      $display("[TB] FAIL %s: got %h, want %h at %0t", name, actual, expected, $time);
    else
      passed_checks++;
  endtask

  task automatic apply_stimulus(input logic r, input logic rdy, input logic redir,
                                input logic [31:0] tgt);
    @(negedge clk);
    rst             = r;
    id_ready        = rdy;
    redirect        = redir;
    redirect_target = tgt;
    #1;
  endtask

  // Model of the PC register, the synchronous memory and the buffer contents.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      pend_valid = 1'b0;
      pc_in      <= '0;
      imem_rdata <= GARBAGE;
    end else begin
      m_req = model_req();
      m_pop = (mq.size() != 0) && id_ready;
      imem_rdata <= m_req ? mem_word(pc_in) : GARBAGE;
      if (redirect) begin
        mq.delete();
        pend_valid = 1'b0;
        pc_in <= redirect_target;
      end else begin
        if (m_pop) void'(mq.pop_front());
        if (pend_valid) mq.push_back({mem_word(pend_pc), pend_pc});
        pend_valid = m_req;
        pend_pc    = pc_in;
        if (m_req) pc_in <= pc_in + 32'd1;
      end
    end
  end

  always @(negedge clk) begin
    #2;
    if (check_en) begin
      exp_req   = model_req();
      exp_instr = (mq.size() != 0) ? mq[0][63:32] : NOP_WORD;
      exp_pc    = (mq.size() != 0) ? mq[0][31:0]  : 32'h0;
      check_output("m_imem_req",  {31'b0, imem_req}, {31'b0, exp_req});
      check_output("m_pc_hold",   {31'b0, pc_hold},  {31'b0, !exp_req});
      check_output("m_imem_addr", imem_addr, pc_in);
      check_output("m_id_valid",  {31'b0, id_valid}, {31'b0, mq.size() != 0});
      check_output("m_id_instr",  id_instr, exp_instr);
      check_output("m_id_pc",     id_pc, exp_pc);
      check_output("m_jump",      {6'b0, id_jump_target}, {6'b0, exp_instr[25:0]});
      check_output("m_branch",    id_branch_off, {{16{exp_instr[15]}}, exp_instr[15:0]});
      check_output("m_occupancy", 32'(occupancy), 32'(mq.size()));
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, want finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [4:0] pattern;
    pattern         = 5'b01101;
    id_ready        = 1'b0;
    redirect        = 1'b0;
    redirect_target = '0;
    #1 rst = 1'b1;
    check_en = 1'b1;

    apply_stimulus(1'b1, 1'b0, 1'b0, 32'h0);
    apply_stimulus(1'b1, 1'b0, 1'b0, 32'h0);
    check_output("rst_imem_req", {31'b0, imem_req}, 32'd0);
    check_output("rst_pc_hold",  {31'b0, pc_hold},  32'd1);
    check_output("rst_id_valid", {31'b0, id_valid}, 32'd0);
    check_output("rst_occ",      32'(occupancy), 32'd0);
    check_output("rst_instr",    id_instr, NOP_WORD);
    check_output("rst_pc",       id_pc, 32'd0);
    check_output("rst_jump",     {6'b0, id_jump_target}, 32'd0);
    check_output("rst_branch",   id_branch_off, 32'd0);

    // Release and stream: first instruction appears two cycles after release.
    apply_stimulus(1'b0, 1'b1, 1'b0, 32'h0);
    check_output("c0_req",   {31'b0, imem_req}, 32'd1);
    check_output("c0_valid", {31'b0, id_valid}, 32'd0);
    apply_stimulus(1'b0, 1'b1, 1'b0, 32'h0);
    check_output("c1_valid", {31'b0, id_valid}, 32'd0);
    check_output("c1_addr",  imem_addr, 32'd1);
    apply_stimulus(1'b0, 1'b1, 1'b0, 32'h0);
    check_output("c2_valid", {31'b0, id_valid}, 32'd1);
    check_output("c2_pc",    id_pc, 32'd0);
    check_output("c2_instr", id_instr, 32'hA000_0000);

    // Backpressure after one handshake: PC freezes at 3.
    apply_stimulus(1'b0, 1'b0, 1'b0, 32'h0);
    check_output("bp_hold", {31'b0, pc_hold}, 32'd1);
    check_output("bp_req",  {31'b0, imem_req}, 32'd0);
    check_output("bp_addr", imem_addr, 32'd3);
    apply_stimulus(1'b0, 1'b0, 1'b0, 32'h0);
    check_output("bp_occ2",  32'(occupancy), 32'd2);
    check_output("bp_addr2", imem_addr, 32'd3);
    apply_stimulus(1'b0, 1'b0, 1'b0, 32'h0);
    check_output("bp_hold2", {31'b0, pc_hold}, 32'd1);
    for (int i = 1; i <= 3; i++) begin
      apply_stimulus(1'b0, 1'b1, 1'b0, 32'h0);
      check_output("bp_drain_valid", {31'b0, id_valid}, 32'd1);
      check_output("bp_drain_pc",    id_pc, 32'(i));
    end
    for (int i = 0; i < 6; i++) begin
      apply_stimulus(1'b0, 1'b1, 1'b0, 32'h0);
      check_output("stream_hold",  {31'b0, pc_hold}, 32'd0);
      check_output("stream_valid", {31'b0, id_valid}, 32'd1);
    end

    // Redirect with one word buffered and one in flight.
    apply_stimulus(1'b0, 1'b1, 1'b1, 32'h40);
    check_output("rd_pre_occ", 32'(occupancy), 32'd1);
    check_output("rd_req",     {31'b0, imem_req}, 32'd0);
    check_output("rd_hold",    {31'b0, pc_hold}, 32'd1);
    apply_stimulus(1'b0, 1'b1, 1'b0, 32'h0);
    check_output("rd1_occ",   32'(occupancy), 32'd0);
    check_output("rd1_valid", {31'b0, id_valid}, 32'd0);
    check_output("rd1_addr",  imem_addr, 32'h40);
    check_output("rd1_req",   {31'b0, imem_req}, 32'd1);
    apply_stimulus(1'b0, 1'b1, 1'b0, 32'h0);
    check_output("rd2_valid", {31'b0, id_valid}, 32'd0);
    apply_stimulus(1'b0, 1'b1, 1'b0, 32'h0);
    check_output("rd3_valid", {31'b0, id_valid}, 32'd1);
    check_output("rd3_pc",    id_pc, 32'h40);
    check_output("rd3_instr", id_instr, 32'hA000_0040);
    for (int i = 0; i < 3; i++) apply_stimulus(1'b0, 1'b1, 1'b0, 32'h0);

    // Field extraction from redirected target words.
    apply_stimulus(1'b0, 1'b1, 1'b1, 32'h80);
    for (int i = 0; i < 3; i++) apply_stimulus(1'b0, 1'b1, 1'b0, 32'h0);
    check_output("fld_instr",  id_instr, 32'h1000_FFFC);
    check_output("fld_branch", id_branch_off, 32'hFFFF_FFFC);
    check_output("fld_jump",   {6'b0, id_jump_target}, 32'h000_FFFC);
    apply_stimulus(1'b0, 1'b1, 1'b0, 32'h0);
    check_output("fld2_pc",   id_pc, 32'h81);
    check_output("fld2_jump", {6'b0, id_jump_target}, 32'h10);
    apply_stimulus(1'b0, 1'b1, 1'b0, 32'h0);

    // Asynchronous reset between edges while one entry is buffered.
    apply_stimulus(1'b0, 1'b1, 1'b0, 32'h0);
    check_output("ar_pre_occ", 32'(occupancy), 32'd1);
    #2 rst = 1'b1;
    #1;
    check_output("ar_valid", {31'b0, id_valid}, 32'd0);
    check_output("ar_occ",   32'(occupancy), 32'd0);
    check_output("ar_req",   {31'b0, imem_req}, 32'd0);
    apply_stimulus(1'b1, 1'b1, 1'b0, 32'h0);
    apply_stimulus(1'b0, 1'b1, 1'b0, 32'h0);
    check_output("ar_c0_addr", imem_addr, 32'd0);
    apply_stimulus(1'b0, 1'b1, 1'b0, 32'h0);
    check_output("ar_c1_valid", {31'b0, id_valid}, 32'd0);
    apply_stimulus(1'b0, 1'b1, 1'b0, 32'h0);
    check_output("ar_c2_valid", {31'b0, id_valid}, 32'd1);
    check_output("ar_c2_pc",    id_pc, 32'd0);

    // Toggling ready exercises simultaneous push/pop and pointer wrap.
    for (int i = 0; i < 20; i++) begin
      apply_stimulus(1'b0, pattern[i % 5], 1'b0, 32'h0);
      check_output("wrap_occ_bound", {31'b0, occupancy <= DEPTH}, 32'd1);
    end
    for (int i = 0; i < 4; i++) apply_stimulus(1'b0, 1'b1, 1'b0, 32'h0);

    @(negedge clk);
    #3;
    check_en = 1'b0;
    $display("%0d/%0d checks passed", passed_checks, total_checks);
    $finish;
  end

endmodule
